// File: rtl/rb_pkg.sv
// Shared constants for the register-bank writeback path.
package rb_pkg;

    localparam int RB_AW    = 5;
    localparam int RB_DW    = 32;
    localparam int RB_NREGS = 32;

    // Register 0 is hard-wired: writes to it are accepted and then dropped.
    localparam logic [RB_AW-1:0] RB_ZERO = '0;

    // Writeback requester indices.
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

endpackage : rb_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances on transfer.
module rr_arbiter
    import rb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    // Index of the requester searched first on the next arbitration.
    logic [PW-1:0] prio_q;
    logic [PW-1:0] prio_d;

    // Grant the first valid requester found going upward from prio_q, wrapping mod N.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        logic          found;
        // NOTE: every variable written in a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, prio_q} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // After a transfer, the requester just served drops to lowest priority.
    always_comb begin
        logic [PW:0] nxt;
        nxt    = {1'b0, grant_idx} + (PW + 1)'(1);
        if (nxt >= (PW + 1)'(N)) begin
            nxt = '0;
        end
        prio_d = prio_q;
        if (advance) begin
            prio_d = nxt[PW-1:0];
        end
    end

    // Pointer register; reset makes requester 0 the first one searched.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // flop samples values from before the edge, regardless of block ordering.
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/rb_wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-bank write port, registered
// write stage, and a per-register pending-write scoreboard for RAW hazard stalls.
module rb_wb_arbiter
    import rb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = RB_AW,
    parameter int DW   = RB_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_wa,
    input  logic [NREQ*DW-1:0]   req_wd,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_wa,
    output logic                 rsv_ready,
    input  logic [AW-1:0]        q_ra1,
    input  logic [AW-1:0]        q_ra2,
    output logic                 q_stall,
    output logic                 rb_write,
    output logic [AW-1:0]        rb_wa,
    output logic [DW-1:0]        rb_wd,
    output logic [(2**AW)-1:0]   busy
);

    localparam int NREGS = 2 ** AW;
    localparam int PW    = $clog2(NREQ);

    logic [AW-1:0]    wa_arr [NREQ];
    logic [DW-1:0]    wd_arr [NREQ];
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    logic             xfer;
    logic [AW-1:0]    sel_wa;
    logic [DW-1:0]    sel_wd;
    logic             commit;

    logic             rb_write_q, rb_write_d;
    logic [AW-1:0]    rb_wa_q,    rb_wa_d;
    logic [DW-1:0]    rb_wd_q,    rb_wd_d;
    logic [NREGS-1:0] busy_q,     busy_d;
    logic [NREGS-1:0] set_vec,    clr_vec;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign wa_arr[g] = req_wa[g*AW +: AW];
        assign wd_arr[g] = req_wd[g*DW +: DW];
    end

    rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    // Select the granted requester; a transfer to register 0 is accepted but not written.
    always_comb begin
        xfer   = |(req_valid & grant);
        sel_wa = wa_arr[grant_idx];
        sel_wd = wd_arr[grant_idx];
        commit = xfer && (sel_wa != AW'(RB_ZERO));
    end

    // Output stage: pulse rb_write for one cycle per commit; address/data hold otherwise.
    always_comb begin
        rb_write_d = commit;
        rb_wa_d    = rb_wa_q;
        rb_wd_d    = rb_wd_q;
        if (commit) begin
            rb_wa_d = sel_wa;
            rb_wd_d = sel_wd;
        end
    end

    // Scoreboard: set on accepted reservation, clear on commit, set wins on collision.
    always_comb begin
        clr_vec   = '0;
        set_vec   = '0;
        rsv_ready = !busy_q[rsv_wa] || (commit && (sel_wa == rsv_wa));
        if (commit) begin
            clr_vec = NREGS'(1) << sel_wa;
        end
        if (rsv_valid && rsv_ready && (rsv_wa != AW'(RB_ZERO))) begin
            set_vec = NREGS'(1) << rsv_wa;
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    // Hazard query against registered busy; a clear landing this cycle is not forwarded.
    always_comb begin
        q_stall = ((q_ra1 != AW'(RB_ZERO)) && busy_q[q_ra1]) ||
                  ((q_ra2 != AW'(RB_ZERO)) && busy_q[q_ra2]);
    end

    // State registers; reset drops any staged write and clears every pending bit.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any
        // other state; a stale pending bit after reset would stall issue forever.
        if (rst) begin
            rb_write_q <= 1'b0;
            rb_wa_q    <= '0;
            rb_wd_q    <= '0;
            busy_q     <= '0;
        end else begin
            rb_write_q <= rb_write_d;
            rb_wa_q    <= rb_wa_d;
            rb_wd_q    <= rb_wd_d;
            busy_q     <= busy_d;
        end
    end

    assign rb_write = rb_write_q;
    assign rb_wa    = rb_wa_q;
    assign rb_wd    = rb_wd_q;
    assign busy     = busy_q;

endmodule : rb_wb_arbiter

// File: tb/tb_rb_wb_arbiter.sv
// Directed testbench for rb_wb_arbiter.
module tb_rb_wb_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*AW-1:0]  req_wa = '0;
    logic [NREQ*DW-1:0]  req_wd = '0;
    logic [NREQ-1:0]     req_ready;
    logic                rsv_valid = 1'b0;
    logic [AW-1:0]       rsv_wa = '0;
    logic                rsv_ready;
    logic [AW-1:0]       q_ra1 = '0;
    logic [AW-1:0]       q_ra2 = '0;
    logic                q_stall;
    logic                rb_write;
    logic [AW-1:0]       rb_wa;
    logic [DW-1:0]       rb_wd;
    logic [31:0]         busy;

    int tests = 0;
    int fails = 0;

    rb_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wa    (req_wa),
        .req_wd    (req_wd),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_wa    (rsv_wa),
        .rsv_ready (rsv_ready),
        .q_ra1     (q_ra1),
        .q_ra2     (q_ra2),
        .q_stall   (q_stall),
        .rb_write  (rb_write),
        .rb_wa     (rb_wa),
        .rb_wd     (rb_wd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        req_valid = '0;
        req_wa    = '0;
        req_wd    = '0;
        rsv_valid = 1'b0;
        rsv_wa    = '0;
        q_ra1     = '0;
        q_ra2     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (rb_write !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle_write cyc %0d got %b exp 0", i, rb_write);
            end
            tests++;
            if (busy !== 32'h0) begin
                fails++;
                $display("FAIL reset_idle_busy cyc %0d got %h exp 0", i, busy);
            end
            tests++;
            if (req_ready !== 2'b00) begin
                fails++;
                $display("FAIL reset_idle_ready cyc %0d got %b exp 00", i, req_ready);
            end
        end
        tests++;
        if (rb_wa !== 5'd0 || rb_wd !== 32'h0) begin
            fails++;
            $display("FAIL reset_wa_wd got %0d/%h exp 0/0", rb_wa, rb_wd);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 2'b01;
        req_wa[0 +: AW] = 5'd5;
        req_wd[0 +: DW] = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL single_ready got %b exp 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        tests++;
        if (rb_write !== 1'b1 || rb_wa !== 5'd5 || rb_wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_write got %b/%0d/%h exp 1/5/deadbeef", rb_write, rb_wa, rb_wd);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rb_write !== 1'b0 || rb_wa !== 5'd5 || rb_wd !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL single_hold got %b/%0d/%h exp 0/5/deadbeef", rb_write, rb_wa, rb_wd);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_gnt;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        do_reset();
        @(negedge clk);
        req_valid = 2'b11;
        req_wa[0  +: AW] = 5'd1;
        req_wd[0  +: DW] = 32'hA0A0_0001;
        req_wa[AW +: AW] = 5'd2;
        req_wd[DW +: DW] = 32'hB0B0_0002;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_wa  = (i % 2 == 0) ? 5'd1 : 5'd2;
            exp_wd  = (i % 2 == 0) ? 32'hA0A0_0001 : 32'hB0B0_0002;
            #1;
            tests++;
            if (req_ready !== exp_gnt) begin
                fails++;
                $display("FAIL rr_grant cyc %0d got %b exp %b", i, req_ready, exp_gnt);
            end
            @(posedge clk);
            #1;
            tests++;
            if (rb_write !== 1'b1 || rb_wa !== exp_wa || rb_wd !== exp_wd) begin
                fails++;
                $display("FAIL rr_write cyc %0d got %b/%0d/%h exp 1/%0d/%h",
                         i, rb_write, rb_wa, rb_wd, exp_wa, exp_wd);
            end
            @(negedge clk);
        end
        req_valid = '0;
        tests++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL rr_busy_unchanged got %h exp 0", busy);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        rsv_valid = 1'b1;
        rsv_wa    = 5'd7;
        #1;
        tests++;
        if (rsv_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_rsv_accept got %b exp 1", rsv_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 32'h0000_0080) begin
            fails++;
            $display("FAIL sb_busy_set got %h exp 00000080", busy);
        end
        @(negedge clk);
        q_ra1 = 5'd7;
        #1;
        tests++;
        if (rsv_ready !== 1'b0 || q_stall !== 1'b1) begin
            fails++;
            $display("FAIL sb_rsv_reject got ready %b stall %b exp 0 1", rsv_ready, q_stall);
        end
        q_ra1 = 5'd3;
        q_ra2 = 5'd7;
        #1;
        tests++;
        if (q_stall !== 1'b1) begin
            fails++;
            $display("FAIL sb_stall_ra2 got %b exp 1", q_stall);
        end
        q_ra2 = 5'd4;
        #1;
        tests++;
        if (q_stall !== 1'b0) begin
            fails++;
            $display("FAIL sb_no_stall got %b exp 0", q_stall);
        end
        q_ra1 = 5'd7;
        q_ra2 = 5'd0;
        @(posedge clk);
        @(negedge clk);
        rsv_valid = 1'b0;
        req_valid = 2'b01;
        req_wa[0 +: AW] = 5'd7;
        req_wd[0 +: DW] = 32'h0000_0077;
        #1;
        tests++;
        if (rsv_ready !== 1'b1 || q_stall !== 1'b1) begin
            fails++;
            $display("FAIL sb_clear_cycle got ready %b stall %b exp 1 1", rsv_ready, q_stall);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        tests++;
        if (rb_write !== 1'b1 || rb_wa !== 5'd7 || busy !== 32'h0 || q_stall !== 1'b0) begin
            fails++;
            $display("FAIL sb_commit got %b/%0d busy %h stall %b exp 1/7 busy 0 stall 0",
                     rb_write, rb_wa, busy, q_stall);
        end
    endtask

    task automatic test_set_wins();
        @(negedge clk);
        rsv_valid = 1'b1;
        rsv_wa    = 5'd7;
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 32'h0000_0080) begin
            fails++;
            $display("FAIL sw_busy_set got %h exp 00000080", busy);
        end
        @(negedge clk);
        req_valid = 2'b01;
        req_wa[0 +: AW] = 5'd7;
        req_wd[0 +: DW] = 32'h1234_5678;
        #1;
        tests++;
        if (rsv_ready !== 1'b1) begin
            fails++;
            $display("FAIL sw_rsv_ready got %b exp 1", rsv_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 32'h0000_0080 || rb_write !== 1'b1 || rb_wa !== 5'd7) begin
            fails++;
            $display("FAIL sw_collision got busy %h write %b wa %0d exp 00000080 1 7",
                     busy, rb_write, rb_wa);
        end
        @(negedge clk);
        rsv_valid = 1'b0;
        @(posedge clk);
        #1;
        req_valid = '0;
        tests++;
        if (busy !== 32'h0) begin
            fails++;
            $display("FAIL sw_final_clear got %h exp 0", busy);
        end
    endtask

    task automatic test_zero_and_reset();
        @(negedge clk);
        req_valid = 2'b01;
        req_wa[0 +: AW] = 5'd0;
        req_wd[0 +: DW] = 32'h0000_0123;
        rsv_valid = 1'b1;
        rsv_wa    = 5'd0;
        #1;
        tests++;
        if (req_ready !== 2'b01 || rsv_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_ready got %b/%b exp 01/1", req_ready, rsv_ready);
        end
        @(posedge clk);
        #1;
        tests++;
        if (rb_write !== 1'b0 || busy !== 32'h0) begin
            fails++;
            $display("FAIL zero_no_write got write %b busy %h exp 0 0", rb_write, busy);
        end
        @(negedge clk);
        rsv_wa = 5'd9;
        req_wa[0 +: AW] = 5'd3;
        req_wd[0 +: DW] = 32'h0000_0033;
        @(posedge clk);
        #1;
        tests++;
        if (rb_write !== 1'b1 || busy !== 32'h0000_0200) begin
            fails++;
            $display("FAIL staged got write %b busy %h exp 1 00000200", rb_write, busy);
        end
        rst = 1'b1;
        clear_inputs();
        #1;
        tests++;
        if (rb_write !== 1'b0 || busy !== 32'h0 || rb_wa !== 5'd0 || rb_wd !== 32'h0) begin
            fails++;
            $display("FAIL async_reset got %b busy %h %0d %h exp 0 0 0 0",
                     rb_write, busy, rb_wa, rb_wd);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (rb_write !== 1'b0 || busy !== 32'h0) begin
            fails++;
            $display("FAIL post_reset got write %b busy %h exp 0 0", rb_write, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_scoreboard();
        test_set_wins();
        test_zero_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rb_wb_arbiter
